// File: rtl/loader_pkg.sv
// Shared definitions for the CPU program loader.
// State encoding and the padding word used past the end of a program.
package loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_FILL  = 3'd1,
    LD_ARM   = 3'd2,
    LD_BURST = 3'd3,
    LD_REARM = 3'd4,
    LD_RUN   = 3'd5,
    LD_DONE  = 3'd6
  } ld_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/program_buffer.sv
// DEPTH x 32 program store for the loader.
// Synchronous write, combinational read.
module program_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Store accepted words; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Buffers a streamed program, then loads it into the CPU
// with a contiguous burst and runs the CPU for a set time.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [CW-1:0] run_cycles,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          CpuReset,
  output logic          LoadInstructions,
  output logic [31:0]   Instruction,
  output logic [AW:0]   word_count,
  output logic          overflow,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_I  = AW'(DEPTH - 1);

  ld_state_t     state;
  logic [AW-1:0] bidx;
  logic [CW-1:0] run_lat;
  logic [CW-1:0] run_cnt;
  logic          xfer;
  logic          we;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic [31:0]   pad_word;

  assign in_ready = (state == LD_FILL);
  assign xfer     = in_valid & in_ready;
  assign we       = xfer & (word_count < DEPTH_W);

  // Read one slot ahead so the registered word lines up with bidx.
  always_comb begin
    raddr = '0;
    if (state == LD_BURST) raddr = AW'(bidx + 1'b1);
  end

  assign pad_word = ({1'b0, raddr} < word_count) ? rdata : NOP_WORD;

  program_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (word_count[AW-1:0]),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Loader FSM with registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state            <= LD_IDLE;
      bidx             <= '0;
      run_lat          <= '0;
      run_cnt          <= '0;
      CpuReset         <= 1'b1;
      LoadInstructions <= 1'b0;
      Instruction      <= NOP_WORD;
      word_count       <= '0;
      overflow         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      unique case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            state      <= LD_FILL;
            run_lat    <= run_cycles;
            word_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        LD_FILL: begin
          if (xfer) begin
            if (we) word_count <= word_count + 1'b1;
            else    overflow   <= 1'b1;
            if (in_last) state <= LD_ARM;
          end
        end
        LD_ARM: begin
          state            <= LD_BURST;
          bidx             <= '0;
          CpuReset         <= 1'b0;
          LoadInstructions <= 1'b1;
          Instruction      <= pad_word;
        end
        LD_BURST: begin
          if (bidx == LAST_I) begin
            state            <= LD_REARM;
            CpuReset         <= 1'b1;
            LoadInstructions <= 1'b0;
            Instruction      <= NOP_WORD;
          end else begin
            bidx        <= bidx + 1'b1;
            Instruction <= pad_word;
          end
        end
        LD_REARM: begin
          state    <= LD_RUN;
          run_cnt  <= run_lat;
          CpuReset <= 1'b0;
        end
        LD_RUN: begin
          if (run_cnt == '0) begin
            state    <= LD_DONE;
            CpuReset <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            run_cnt <= run_cnt - 1'b1;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the pipelined CPU's instruction-load path.
- Accepts a program as a valid/ready word stream that may stall arbitrarily, and buffers it internally.
- Then drives the CPU's `Reset`, `LoadInstructions` and `Instruction` inputs in the exact contiguous sequence the CPU's free-running load-address counter requires.
- Finally releases the CPU to run for a programmed number of cycles and reports completion.

Parameters:
- DEPTH, 32, instruction memory words loaded per burst; power of two.
- AW, 5, log2(DEPTH).
- CW, 16, width of run-cycle counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; begins accepting a program. Honoured only in IDLE or DONE.
- run_cycles  input  CW  CPU run length, sampled on the cycle start is accepted.
- in_valid  input  1  stream word valid.
- in_data  input  32  instruction word.
- in_last  input  1  marks final word of program; qualified by in_valid.
- in_ready  output  1  loader accepts word this cycle.
- CpuReset  output  1  drives CPU Reset.
- LoadInstructions  output  1  drives CPU LoadInstructions.
- Instruction  output  32  drives CPU Instruction.
- word_count  output  AW+1  words accepted, saturating at DEPTH.
- overflow  output  1  sticky; program exceeded DEPTH.
- busy  output  1  high in FILL through RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset values:
  - state=IDLE, CpuReset=1, LoadInstructions=0, Instruction=0.
  - in_ready=0, word_count=0, overflow=0, busy=0, done=0.
  - Buffer contents need not be cleared.
- A word transfers on a cycle with in_valid & in_ready. All outputs are registered except in_ready, which is decoded from state.
- IDLE: CpuReset=1. On start: latch run_cycles, clear word_count and overflow, go to FILL.
- FILL: CpuReset=1, in_ready=1.
  - Each transfer with word_count<DEPTH writes buf[word_count] and increments word_count.
  - A transfer with word_count==DEPTH drops the data and sets overflow. in_ready stays high so the source drains.
  - A transfer with in_last=1 goes to ARM on the next cycle. Data in that same cycle is stored or dropped by the rules above.
  - start is ignored in FILL.
- ARM: one cycle, CpuReset=1, so the CPU's load counter reads 0 on the following cycle. Go to BURST with index i=0.
- BURST: exactly DEPTH cycles, CpuReset=0, LoadInstructions=1.
  - Instruction = buf[i] if i<word_count, else 32'h0000_0000 (NOP padding).
  - i increments each cycle; after i==DEPTH-1 go to REARM.
  - Instruction word k appears in the k-th cycle after CpuReset falls, aligned with CPU load address k.
- REARM: one cycle, CpuReset=1, LoadInstructions=0, Instruction=0. This returns the CPU PC to 0. Load run counter with latched run_cycles and go to RUN.
- RUN: CpuReset=0, LoadInstructions=0.
  - Counter decrements each cycle; at the cycle the count reaches 0, go to DONE.
  - run_cycles==0 means RUN lasts 1 cycle.
- DONE: CpuReset=1 (CPU frozen), done=1. start re-enters FILL; word_count and overflow are held until then.
- Reset asserted in any state, including mid-BURST, forces reset values on the next edge. The CPU memory may then hold a partial program.
- Simultaneous start and in_valid in IDLE/DONE: start is taken, and the word is not accepted (in_ready=0 that cycle).

Decomposition:
- Shared package `loader_pkg`: state encoding localparams, LD_IDLE, LD_FILL, LD_ARM, LD_BURST, LD_REARM, LD_RUN, LD_DONE (3-bit); constant NOP_WORD=32'h0.
- One sub-module, `program_buffer`: DEPTH x 32 register array.
  - Synchronous write port: we, waddr, wdata.
  - Combinational read port: raddr → rdata.
  - The loader registers the padding mux output.

Test Plan:
- Stream 3 words with in_valid gaps, last on word 3, run_cycles=10 → ARM 1 cycle, then 32 BURST cycles showing words 0–2 then 29 zeros. REARM 1 cycle, RUN 11 cycles, done=1, word_count=3, overflow=0.
- Stream 34 words (last on 34th) → word_count=32, overflow=1. BURST outputs words 0–31 only, and in_ready stays high until word 34.
- Single word with in_last on first beat (32'h2001_0005) → BURST cycle 0 shows 32'h2001_0005, cycles 1–31 show 0.
- Assert Reset during BURST cycle 10 → next cycle CpuReset=1, LoadInstructions=0, busy=0, state IDLE; a subsequent start performs a full fresh load.
- Pulse start during FILL and RUN → ignored, with no change to word_count or the run counter. Pulse start in DONE → re-enters FILL with word_count=0.
- run_cycles=0 → RUN lasts exactly 1 cycle before done=1.
